// File: rtl/home_pkg.sv
// Shared definitions for the home-screen action request controller and its status logic.
package home_pkg;

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_REQ_EAT   = 3'd1;
  localparam logic [2:0] S_REQ_SLEEP = 3'd2;
  localparam logic [2:0] S_RELEASE   = 3'd3;
  localparam logic [2:0] S_COOLDOWN  = 3'd4;

  localparam logic [1:0] ACT_NONE  = 2'd0;
  localparam logic [1:0] ACT_EAT   = 2'd1;
  localparam logic [1:0] ACT_SLEEP = 2'd2;

  localparam logic [7:0] SATED_LEVEL_DEF = 8'd0;

  // One counter serves both timeout and cooldown, so size it for the larger limit.
  function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m == 0) ? 1 : $clog2(m + 1);
  endfunction

endpackage

// File: rtl/home_action_ctrl_if.sv
// Button/stat inputs and held-request outputs between the controller and its neighbours.
interface home_action_if;
  logic       keyEat;
  logic       keySleep;
  logic       done;
  logic [7:0] hunger;
  logic [7:0] sleepiness;
  logic       doEat;
  logic       doSleep;
  logic       busy;
  logic       rejected;
  logic       timedOut;
  logic [1:0] lastAction;

  modport master (
    output keyEat, keySleep, done, hunger, sleepiness,
    input  doEat, doSleep, busy, rejected, timedOut, lastAction
  );
  modport slave (
    input  keyEat, keySleep, done, hunger, sleepiness,
    output doEat, doSleep, busy, rejected, timedOut, lastAction
  );
endinterface

// File: rtl/home_action_ctrl_key_edge_sync.sv
// Two-flop synchronizer followed by a registered rising-edge pulse for one raw key.
module key_edge_sync (
  input  logic clk,
  input  logic resetn,
  input  logic key_i,
  output logic pulse_o
);
  logic meta_q, sync_q, prev_q, pulse_q;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      meta_q  <= 1'b0;
      sync_q  <= 1'b0;
      prev_q  <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      meta_q  <= key_i;
      sync_q  <= meta_q;
      prev_q  <= sync_q;
      pulse_q <= sync_q & ~prev_q;
    end
  end

  assign pulse_o = pulse_q;
endmodule

// File: rtl/home_action_ctrl.sv
// Turns key presses into a held eat/sleep request, waits for done, releases and cools down.
module home_action_ctrl
  import home_pkg::*;
#(
  parameter int unsigned COOLDOWN_CYCLES = 50_000_000,
  parameter int unsigned TIMEOUT_CYCLES  = 300_000_000,
  parameter logic [7:0]  SATED_LEVEL     = SATED_LEVEL_DEF
) (
  input  logic         clk,
  input  logic         resetn,
  home_action_if.slave bus
);
  localparam int unsigned CNT_W = cnt_width(TIMEOUT_CYCLES, COOLDOWN_CYCLES);

  logic             eat_p, sleep_p, any_p;
  logic [2:0]       state_q;
  logic [CNT_W-1:0] cnt_q, cnt_inc;
  logic             doEat_q, doSleep_q, rej_q, to_q;
  logic [1:0]       last_q;
  logic             cnt_tmo_hit, cnt_cool_hit;

  key_edge_sync u_eat   (.clk(clk), .resetn(resetn), .key_i(bus.keyEat),   .pulse_o(eat_p));
  key_edge_sync u_sleep (.clk(clk), .resetn(resetn), .key_i(bus.keySleep), .pulse_o(sleep_p));

  assign any_p        = eat_p | sleep_p;
  assign cnt_inc      = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
  assign cnt_tmo_hit  = (32'(cnt_q) + 32'd1) >= TIMEOUT_CYCLES;
  assign cnt_cool_hit = (32'(cnt_q) + 32'd1) >= COOLDOWN_CYCLES;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      doEat_q   <= 1'b0;
      doSleep_q <= 1'b0;
      rej_q     <= 1'b0;
      to_q      <= 1'b0;
      last_q    <= ACT_NONE;
    end else begin
      rej_q <= 1'b0;
      to_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          cnt_q <= '0;
          // An eat press owns the cycle even when refused; a coincident sleep press is dropped.
          if (eat_p) begin
            if (bus.hunger != SATED_LEVEL) begin
              state_q <= S_REQ_EAT;
              doEat_q <= 1'b1;
            end else begin
              rej_q <= 1'b1;
            end
          end else if (sleep_p) begin
            if (bus.sleepiness != SATED_LEVEL) begin
              state_q   <= S_REQ_SLEEP;
              doSleep_q <= 1'b1;
            end else begin
              rej_q <= 1'b1;
            end
          end
        end
        S_REQ_EAT, S_REQ_SLEEP: begin
          rej_q <= any_p;
          if (bus.done) begin
            state_q   <= S_RELEASE;
            doEat_q   <= 1'b0;
            doSleep_q <= 1'b0;
            cnt_q     <= '0;
            last_q    <= (state_q == S_REQ_EAT) ? ACT_EAT : ACT_SLEEP;
          end else if (cnt_tmo_hit) begin
            state_q   <= S_RELEASE;
            doEat_q   <= 1'b0;
            doSleep_q <= 1'b0;
            cnt_q     <= '0;
            to_q      <= 1'b1;
          end else begin
            cnt_q <= cnt_inc;
          end
        end
        S_RELEASE: begin
          rej_q <= any_p;
          cnt_q <= '0;
          if (!bus.done) state_q <= S_COOLDOWN;
        end
        S_COOLDOWN: begin
          rej_q <= any_p;
          if (cnt_cool_hit) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_inc;
          end
        end
        default: begin
          state_q   <= S_IDLE;
          cnt_q     <= '0;
          doEat_q   <= 1'b0;
          doSleep_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.doEat      = doEat_q;
  assign bus.doSleep    = doSleep_q;
  assign bus.busy       = (state_q != S_IDLE);
  assign bus.rejected   = rej_q;
  assign bus.timedOut   = to_q;
  assign bus.lastAction = last_q;
endmodule

// File: tb/tb_home_action_ctrl.sv
// Self-checking bench: vector table, directed corner sequences and a random run against a reference model.
module tb_home_action_ctrl;
  import home_pkg::*;

  localparam int COOL = 4;
  localparam int TMO  = 20;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  home_action_if bus();

  home_action_ctrl #(.COOLDOWN_CYCLES(COOL), .TIMEOUT_CYCLES(TMO), .SATED_LEVEL(8'd0)) dut (
    .clk(clk), .resetn(resetn), .bus(bus)
  );

  int tests_run = 0;
  int tests_failed = 0;
  int cyc = 0;

  // Reference model: a request episode with a remaining-time budget, a release flag and a cooldown budget.
  int         m_kind;      // 0 none, 1 eat, 2 sleep
  int         m_req_left;
  int         m_cool_left;
  bit         m_rel, m_rej, m_to;
  logic [1:0] m_last;
  bit         ke_h[4], ks_h[4];   // key values sampled at the last four edges, newest first

  int obs_rej, obs_dsl, obs_de_rise;
  bit prev_de;

  task automatic model_edge(input bit rn, input bit ke, input bit ks, input bit dn,
                            input logic [7:0] hu, input logic [7:0] sl);
    bit ee, se;
    if (!rn) begin
      m_kind = 0; m_req_left = 0; m_cool_left = 0; m_rel = 0; m_rej = 0; m_to = 0; m_last = 2'd0;
      for (int i = 0; i < 4; i++) begin ke_h[i] = 1'b0; ks_h[i] = 1'b0; end
      return;
    end
    ee = ke_h[2] && !ke_h[3];
    se = ks_h[2] && !ks_h[3];
    for (int i = 3; i > 0; i--) begin ke_h[i] = ke_h[i-1]; ks_h[i] = ks_h[i-1]; end
    ke_h[0] = ke; ks_h[0] = ks;
    m_rej = 0; m_to = 0;
    if (m_kind != 0) begin
      m_rej = ee || se;
      m_req_left--;
      if (dn) begin m_last = 2'(m_kind); m_kind = 0; m_rel = 1; end
      else if (m_req_left == 0) begin m_to = 1; m_kind = 0; m_rel = 1; end
    end else if (m_rel) begin
      m_rej = ee || se;
      if (!dn) begin m_rel = 0; m_cool_left = (COOL > 0) ? COOL : 1; end
    end else if (m_cool_left > 0) begin
      m_rej = ee || se;
      m_cool_left--;
    end else if (ee) begin
      if (hu != 8'd0) begin m_kind = 1; m_req_left = TMO; end else m_rej = 1;
    end else if (se) begin
      if (sl != 8'd0) begin m_kind = 2; m_req_left = TMO; end else m_rej = 1;
    end
  endtask

  function automatic logic [6:0] model_out();
    bit busy;
    busy = (m_kind != 0) || m_rel || (m_cool_left > 0);
    return {m_kind == 1, m_kind == 2, busy, m_rej, m_to, m_last};
  endfunction

  function automatic logic [6:0] dut_out();
    return {bus.doEat, bus.doSleep, bus.busy, bus.rejected, bus.timedOut, bus.lastAction};
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s @cycle %0d: got 0x%0h, expected 0x%0h", nm, cyc, act, exp);
    end
  endtask

  task automatic step(input bit rn, input bit ke, input bit ks, input bit dn,
                      input logic [7:0] hu, input logic [7:0] sl);
    resetn = rn; bus.keyEat = ke; bus.keySleep = ks; bus.done = dn;
    bus.hunger = hu; bus.sleepiness = sl;
    @(posedge clk);
    model_edge(rn, ke, ks, dn, hu, sl);
    #1;
    cyc++;
    check("model", 32'(dut_out()), 32'(model_out()));
    if (bus.rejected) obs_rej++;
    if (bus.doSleep) obs_dsl++;
    if (bus.doEat && !prev_de) obs_de_rise++;
    prev_de = bus.doEat;
  endtask

  task automatic do_reset();
    step(1'b0, 0, 0, 0, 8'd40, 8'd50);
    step(1'b1, 0, 0, 0, 8'd40, 8'd50);
    obs_rej = 0; obs_dsl = 0; obs_de_rise = 0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 0, 0, 0, 8'd40, 8'd50);
  endtask

  task automatic wait_do_eat(input string nm);
    int n = 0;
    while (!bus.doEat && n < 10) begin idle(1); n++; end
    check(nm, 32'(bus.doEat), 32'd1);
  endtask

  task automatic drain();
    int n = 0;
    while (bus.busy && n < 60) begin idle(1); n++; end
    check("drain_busy", 32'(bus.busy), 32'd0);
    idle(4);
  endtask

  typedef struct {
    int n; bit ke; bit ks; bit dn; logic [7:0] hu; logic [7:0] sl; logic [6:0] exp;
  } vec_t;
  vec_t tbl[$];

  initial begin
    int n;
    bit rke, rks, rdn, rrn;
    logic [7:0] rhu, rsl;

    // exp = {doEat, doSleep, busy, rejected, timedOut, lastAction}
    tbl.push_back('{1, 1'b1, 1'b0, 1'b0, 8'd40, 8'd50, 7'b0000000});
    tbl.push_back('{2, 1'b0, 1'b0, 1'b0, 8'd40, 8'd50, 7'b0000000});
    tbl.push_back('{6, 1'b0, 1'b0, 1'b0, 8'd40, 8'd50, 7'b1010000});
    tbl.push_back('{1, 1'b0, 1'b0, 1'b1, 8'd40, 8'd50, 7'b0010001});
    tbl.push_back('{4, 1'b0, 1'b0, 1'b0, 8'd40, 8'd50, 7'b0010001});
    tbl.push_back('{2, 1'b0, 1'b0, 1'b0, 8'd40, 8'd50, 7'b0000001});
    tbl.push_back('{1, 1'b1, 1'b1, 1'b0, 8'd0,  8'd9,  7'b0000001});
    tbl.push_back('{2, 1'b0, 1'b0, 1'b0, 8'd0,  8'd9,  7'b0000001});
    tbl.push_back('{1, 1'b0, 1'b0, 1'b0, 8'd0,  8'd9,  7'b0001001});
    tbl.push_back('{3, 1'b0, 1'b0, 1'b0, 8'd0,  8'd9,  7'b0000001});
    tbl.push_back('{1, 1'b0, 1'b1, 1'b0, 8'd0,  8'd0,  7'b0000001});
    tbl.push_back('{2, 1'b0, 1'b0, 1'b0, 8'd0,  8'd0,  7'b0000001});
    tbl.push_back('{1, 1'b0, 1'b0, 1'b0, 8'd0,  8'd0,  7'b0001001});
    tbl.push_back('{2, 1'b0, 1'b0, 1'b0, 8'd0,  8'd0,  7'b0000001});

    resetn = 1'b0; bus.keyEat = 0; bus.keySleep = 0; bus.done = 0;
    bus.hunger = 8'd40; bus.sleepiness = 8'd50;
    prev_de = 1'b0;

    step(1'b0, 0, 0, 0, 8'd40, 8'd50);
    check("reset_state", 32'(dut_out()), 32'd0);
    step(1'b1, 0, 0, 0, 8'd40, 8'd50);

    // Eat accepted and completed, then a sated double press and a sated sleep press.
    foreach (tbl[r])
      for (int k = 0; k < tbl[r].n; k++) begin
        step(1'b1, tbl[r].ke, tbl[r].ks, tbl[r].dn, tbl[r].hu, tbl[r].sl);
        check($sformatf("tbl_row%0d", r), 32'(dut_out()), 32'(tbl[r].exp));
      end

    // Sleep request times out with done held low.
    do_reset();
    step(1'b1, 0, 1, 0, 8'd40, 8'd30);
    n = 0;
    while (!bus.doSleep && n < 10) begin step(1'b1, 0, 0, 0, 8'd40, 8'd30); n++; end
    check("t3_latency", 32'(n), 32'd3);
    n = 0;
    while (!bus.timedOut && n < 40) begin step(1'b1, 0, 0, 0, 8'd40, 8'd30); n++; end
    check("t3_timeout_cycles", 32'(n), 32'(TMO));
    check("t3_doSleep_low", 32'(bus.doSleep), 32'd0);
    check("t3_lastAction", 32'(bus.lastAction), 32'(ACT_NONE));
    drain();

    // Presses while requesting and while cooling down are refused.
    do_reset();
    step(1'b1, 1, 0, 0, 8'd40, 8'd50);
    wait_do_eat("t4_first_doEat");
    step(1'b1, 0, 1, 0, 8'd40, 8'd50);
    idle(5);
    step(1'b1, 1, 0, 1, 8'd40, 8'd50);
    drain();
    check("t4_rejects", 32'(obs_rej), 32'd2);
    check("t4_no_doSleep", 32'(obs_dsl), 32'd0);
    step(1'b1, 1, 0, 0, 8'd40, 8'd50);
    wait_do_eat("t4_second_doEat");
    step(1'b1, 0, 0, 1, 8'd40, 8'd50);
    drain();

    // Reset while the request is held, then a normal press.
    do_reset();
    step(1'b1, 1, 0, 0, 8'd40, 8'd50);
    wait_do_eat("t5_doEat");
    step(1'b0, 0, 0, 0, 8'd40, 8'd50);
    check("t5_reset_outs", 32'(dut_out()), 32'd0);
    step(1'b1, 1, 0, 0, 8'd40, 8'd50);
    n = 0;
    while (!bus.doEat && n < 10) begin idle(1); n++; end
    check("t5_latency", 32'(n), 32'd3);
    step(1'b1, 0, 0, 1, 8'd40, 8'd50);
    drain();

    // A held key yields exactly one episode; the action stage echoes the request as done.
    do_reset();
    for (int i = 0; i < 110; i++) step(1'b1, 1, 0, bus.doEat, 8'd40, 8'd50);
    check("t6_one_episode", 32'(obs_de_rise), 32'd1);
    check("t6_lastAction", 32'(bus.lastAction), 32'(ACT_EAT));
    drain();

    // Random traffic against the model.
    do_reset();
    rke = 0; rks = 0; rhu = 8'd10; rsl = 8'd10;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 9) == 0) rke = ~rke;
      if ($urandom_range(0, 9) == 0) rks = ~rks;
      if ($urandom_range(0, 19) == 0) rhu = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom);
      if ($urandom_range(0, 19) == 0) rsl = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom);
      rdn = (i < 1500) ? ($urandom_range(0, 4) == 0) : ($urandom_range(0, 39) == 0);
      rrn = ($urandom_range(0, 499) != 0);
      step(rrn, rke, rks, rdn, rhu, rsl);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
